// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction type codes and hazard controller FSM states.
package cpu_pkg;

   typedef enum logic [4:0] {
      ITYPE_NOP      = 5'd0,
      ITYPE_LOAD_IMM = 5'd1,
      ITYPE_LOAD_MEM = 5'd2,
      ITYPE_STORE    = 5'd3,
      ITYPE_ALU      = 5'd4,
      ITYPE_JUMP     = 5'd5
   } itype_e;

   typedef enum logic [1:0] {
      CTRL_RUN    = 2'd0,
      CTRL_STALL  = 2'd1,
      CTRL_SQUASH = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable 4-bit down counter; stops at zero and flags it.
module cycle_down_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= 4'd0;
      else if (load)
         count <= load_val;
      else if (dec && (count != 4'd0))
         count <= count - 4'd1;
   end

   assign zero = (count == 4'd0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use stall and taken-jump squash/redirect sequencer beside the decode stage.
// Optional cycle counters for stall/squash are enabled by HAZARD_STALL_CONTROLLER_PERF_EN.
//
// state       | meaning
// CTRL_RUN    | normal flow; stall asserted combinationally on a load-use hazard
// CTRL_STALL  | remaining load-latency cycles, decode and fetch held
// CTRL_SQUASH | wrong-path decode contents squashed after a redirect
module hazard_stall_controller
   import cpu_pkg::*;
#(
   parameter int LOAD_LATENCY  = 2,
   parameter int SQUASH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  decode_instruction_type,
   input  logic [4:0]  decode_src_reg_0,
   input  logic        decode_src_reg_0_valid,
   input  logic [4:0]  decode_src_reg_1,
   input  logic        decode_src_reg_1_valid,
   input  logic [4:0]  ex_instruction_type,
   input  logic [4:0]  ex_dest_reg,
   input  logic [31:0] jump_condition,
   input  logic [31:0] jump_address,
   output logic        stall,
   output logic        squash,
   output logic        pc_hold,
   output logic        pc_load,
   output logic [31:0] pc_target,
   output logic [1:0]  ctrl_state
`ifdef HAZARD_STALL_CONTROLLER_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_squash_cycles
`endif
);

   // The detecting RUN cycle already stalls, so STALL itself lasts LOAD_LATENCY-1 cycles.
   localparam logic [3:0] STALL_LOAD  = 4'((LOAD_LATENCY > 1) ? (LOAD_LATENCY - 2) : 0);
   localparam logic [3:0] SQUASH_LOAD = 4'(SQUASH_CYCLES - 1);

   ctrl_state_e state, state_next;
   logic        hazard, taken, take_jump;
   logic        cnt_load, cnt_dec, cnt_zero;
   logic [3:0]  cnt_load_val;

   assign hazard = (ex_instruction_type == ITYPE_LOAD_MEM) &&
                   ((decode_src_reg_0_valid && (decode_src_reg_0 == ex_dest_reg)) ||
                    (decode_src_reg_1_valid && (decode_src_reg_1 == ex_dest_reg)));
   assign taken  = (decode_instruction_type == ITYPE_JUMP) && (jump_condition != 32'd0) && !hazard;

   cycle_down_counter u_cycle_down_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= CTRL_RUN;
      else
         state <= state_next;
   end

   always_comb begin
      state_next   = state;
      cnt_load     = 1'b0;
      cnt_load_val = 4'd0;
      cnt_dec      = 1'b0;
      take_jump    = 1'b0;
      case (state)
         CTRL_RUN: begin
            if (hazard) begin
               if (LOAD_LATENCY > 1) begin
                  state_next   = CTRL_STALL;
                  cnt_load     = 1'b1;
                  cnt_load_val = STALL_LOAD;
               end
            end else if (taken) begin
               state_next   = CTRL_SQUASH;
               cnt_load     = 1'b1;
               cnt_load_val = SQUASH_LOAD;
               take_jump    = 1'b1;
            end
         end
         CTRL_STALL, CTRL_SQUASH: begin
            if (cnt_zero)
               state_next = CTRL_RUN;
            else
               cnt_dec = 1'b1;
         end
         default: state_next = CTRL_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_load   <= 1'b0;
         pc_target <= 32'd0;
      end else begin
         pc_load <= take_jump;
         if (take_jump)
            pc_target <= jump_address;
      end
   end

   // Gated by rst so a hazard pattern on the inputs cannot stall during reset.
   assign stall      = rst && ((state == CTRL_STALL) || ((state == CTRL_RUN) && hazard));
   assign squash     = (state == CTRL_SQUASH);
   assign pc_hold    = stall;
   assign ctrl_state = state;

`ifdef HAZARD_STALL_CONTROLLER_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cycles  <= 32'd0;
         perf_squash_cycles <= 32'd0;
      end else begin
         if (stall && (perf_stall_cycles != 32'hFFFF_FFFF))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (squash && (perf_squash_cycles != 32'hFFFF_FFFF))
            perf_squash_cycles <= perf_squash_cycles + 32'd1;
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed table-driven bench for hazard_stall_controller (default parameters, no perf counters).
module tb_hazard_stall_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  decode_instruction_type = '0;
   logic [4:0]  decode_src_reg_0 = '0;
   logic        decode_src_reg_0_valid = 1'b0;
   logic [4:0]  decode_src_reg_1 = '0;
   logic        decode_src_reg_1_valid = 1'b0;
   logic [4:0]  ex_instruction_type = '0;
   logic [4:0]  ex_dest_reg = '0;
   logic [31:0] jump_condition = '0;
   logic [31:0] jump_address = '0;
   logic        stall, squash, pc_hold, pc_load;
   logic [31:0] pc_target;
   logic [1:0]  ctrl_state;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_stall_controller #(.LOAD_LATENCY(2), .SQUASH_CYCLES(1)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .decode_instruction_type (decode_instruction_type),
      .decode_src_reg_0        (decode_src_reg_0),
      .decode_src_reg_0_valid  (decode_src_reg_0_valid),
      .decode_src_reg_1        (decode_src_reg_1),
      .decode_src_reg_1_valid  (decode_src_reg_1_valid),
      .ex_instruction_type     (ex_instruction_type),
      .ex_dest_reg             (ex_dest_reg),
      .jump_condition          (jump_condition),
      .jump_address            (jump_address),
      .stall                   (stall),
      .squash                  (squash),
      .pc_hold                 (pc_hold),
      .pc_load                 (pc_load),
      .pc_target               (pc_target),
      .ctrl_state              (ctrl_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  dtype;
      logic [4:0]  s0;
      logic        s0v;
      logic [4:0]  s1;
      logic        s1v;
      logic [4:0]  extype;
      logic [4:0]  exdest;
      logic [31:0] jcond;
      logic [31:0] jaddr;
      logic        e_stall;
      logic        e_squash;
      logic        e_pcl;
      logic [31:0] e_tgt;
      logic [1:0]  e_state;
   } vec_t;

   vec_t vecs[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic e_stall, input logic e_squash,
                            input logic e_pcl, input logic [31:0] e_tgt, input logic [1:0] e_state);
      chk({tag, ".stall"},      32'(stall),      32'(e_stall));
      chk({tag, ".pc_hold"},    32'(pc_hold),    32'(e_stall));
      chk({tag, ".squash"},     32'(squash),     32'(e_squash));
      chk({tag, ".pc_load"},    32'(pc_load),    32'(e_pcl));
      chk({tag, ".pc_target"},  pc_target,       e_tgt);
      chk({tag, ".ctrl_state"}, 32'(ctrl_state), 32'(e_state));
   endtask

   task automatic drive(input logic [4:0] dtype, input logic [4:0] s0, input logic s0v,
                        input logic [4:0] s1, input logic s1v, input logic [4:0] extype,
                        input logic [4:0] exdest, input logic [31:0] jcond, input logic [31:0] jaddr);
      decode_instruction_type = dtype;
      decode_src_reg_0        = s0;
      decode_src_reg_0_valid  = s0v;
      decode_src_reg_1        = s1;
      decode_src_reg_1_valid  = s1v;
      ex_instruction_type     = extype;
      ex_dest_reg             = exdest;
      jump_condition          = jcond;
      jump_address            = jaddr;
   endtask

   task automatic drive_idle();
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
   endtask

   initial begin
      //          dtype  s0  v   s1  v   ex   dst  jcond          jaddr          stl sq pcl tgt            st
      vecs[0]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'h0,          2'd0};
      vecs[1]  = '{5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd2, 5'd7, 32'd0, 32'd0,          1'b1, 1'b0, 1'b0, 32'h0,          2'd0};
      vecs[2]  = '{5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd2, 5'd7, 32'd0, 32'd0,          1'b1, 1'b0, 1'b0, 32'h0,          2'd1};
      vecs[3]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'h0,          2'd0};
      vecs[4]  = '{5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd4, 5'd7, 32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'h0,          2'd0};
      vecs[5]  = '{5'd0, 5'd7, 1'b0, 5'd7, 1'b0, 5'd2, 5'd7, 32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'h0,          2'd0};
      vecs[6]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd2, 5'd0, 32'd0, 32'd0,          1'b1, 1'b0, 1'b0, 32'h0,          2'd0};
      vecs[7]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0,          1'b1, 1'b0, 1'b0, 32'h0,          2'd1};
      vecs[8]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'h0,          2'd0};
      vecs[9]  = '{5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd1, 32'h40,         1'b0, 1'b0, 1'b0, 32'h0,          2'd0};
      vecs[10] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0,          1'b0, 1'b1, 1'b1, 32'h40,         2'd2};
      vecs[11] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'h40,         2'd0};
      vecs[12] = '{5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'h80,         1'b0, 1'b0, 1'b0, 32'h40,         2'd0};
      vecs[13] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'h40,         2'd0};
      vecs[14] = '{5'd5, 5'd3, 1'b1, 5'd0, 1'b0, 5'd2, 5'd3, 32'd1, 32'h100,        1'b1, 1'b0, 1'b0, 32'h40,         2'd0};
      vecs[15] = '{5'd5, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 32'd1, 32'h100,        1'b1, 1'b0, 1'b0, 32'h40,         2'd1};
      vecs[16] = '{5'd5, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 32'd1, 32'h100,        1'b0, 1'b0, 1'b0, 32'h40,         2'd0};
      vecs[17] = '{5'd5, 5'd3, 1'b1, 5'd0, 1'b0, 5'd2, 5'd3, 32'd1, 32'h200,        1'b0, 1'b1, 1'b1, 32'h100,        2'd2};
      vecs[18] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'h100,        2'd0};
      vecs[19] = '{5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h100, 2'd0};
      vecs[20] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0,          1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF,  2'd2};
      vecs[21] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0,          1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF,  2'd0};

      // reset with random inputs
      #1 rst = 1'b0;
      drive(5'($urandom_range(0, 5)), 5'($urandom), 1'b1, 5'($urandom), 1'b1,
            5'd2, 5'($urandom), $urandom, $urandom);
      ex_dest_reg = decode_src_reg_0;
      @(posedge clk); #2;
      check_all("reset", 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      @(posedge clk); #2;
      drive_idle();
      rst = 1'b1;

      for (int i = 0; i < 22; i++) begin
         @(posedge clk); #2;
         drive(vecs[i].dtype, vecs[i].s0, vecs[i].s0v, vecs[i].s1, vecs[i].s1v,
               vecs[i].extype, vecs[i].exdest, vecs[i].jcond, vecs[i].jaddr);
         #2;
         check_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_squash,
                   vecs[i].e_pcl, vecs[i].e_tgt, vecs[i].e_state);
      end

      // reset asserted in the middle of STALL
      @(posedge clk); #2;
      drive(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd2, 5'd5, 32'd0, 32'd0);
      #2 check_all("mid_stall.run", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 2'd0);
      @(posedge clk); #2;
      check_all("mid_stall.stall", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 2'd1);
      rst = 1'b0;
      #1 check_all("mid_stall.rst", 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      @(posedge clk); #2;
      drive_idle();
      rst = 1'b1;
      @(posedge clk); #4;
      check_all("mid_stall.after", 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);

      // reset asserted in the middle of SQUASH drops the redirect
      @(posedge clk); #2;
      drive(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd3, 32'h300);
      @(posedge clk); #2;
      drive_idle();
      #2 check_all("mid_squash.sq", 1'b0, 1'b1, 1'b1, 32'h300, 2'd2);
      rst = 1'b0;
      #1 check_all("mid_squash.rst", 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #4;
      check_all("mid_squash.after", 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      @(posedge clk); #4;
      check_all("mid_squash.after2", 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
